// File: rtl/cavlc_scan_prep_pkg.sv
// Shared definitions for the CAVLC scan-preparation block: zigzag map,
// controller states and the coefficient word type of the quant/entropy path.
package cavlc_scan_prep_pkg;

  localparam int COEF_MSB = 31;

  typedef logic signed [COEF_MSB:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Scan position -> raster index (4*row+col) for a 4x4 frame block.
  localparam logic [3:0] ZIGZAG [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

endpackage

// File: rtl/cavlc_scan_prep.sv
// Zigzag-reorders a 4x4 coefficient block, computes TotalCoeff/TrailingOnes/
// TotalZeros, then streams nonzero levels with run_before in reverse scan order.
module cavlc_scan_prep
  import cavlc_scan_prep_pkg::*;
#(
  parameter int BIT_LENGTH = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [BIT_LENGTH:0] quantized [16],
  output logic                    stats_valid,
  output logic [4:0]              total_coeff,
  output logic [1:0]              trailing_ones,
  output logic [3:0]              total_zeros,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic signed [BIT_LENGTH:0] coef_level,
  output logic [3:0]              coef_run,
  output logic                    coef_last,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on an edge where valid && ready; a source
  // holds its payload stable while valid is high and ready is low.

  state_t state, state_nxt;

  logic signed [BIT_LENGTH:0] scan [16];
  logic [3:0] run [16];
  logic [3:0] pos, ptr, zcnt, last_idx, first_idx;
  logic [4:0] tc;
  logic [1:0] t1;
  logic       seen;

  logic signed [BIT_LENGTH:0] cur;
  logic       nz, mag1;
  logic [4:0] tc_n;
  logic [1:0] t1_n;
  logic [3:0] zc_n, last_n, first_n;
  logic [4:0] tz_w;
  logic       beat_take;

  always_comb begin
    cur     = scan[pos];
    nz      = (cur != '0);
    // Full-width test: -1 is the all-ones word.
    mag1    = (cur == {{BIT_LENGTH{1'b0}}, 1'b1}) || (&cur);
    tc_n    = nz ? tc + 5'd1 : tc;
    t1_n    = !nz ? t1 : (mag1 ? ((t1 == 2'd3) ? 2'd3 : t1 + 2'd1) : 2'd0);
    zc_n    = nz ? 4'd0 : zcnt + 4'd1;
    last_n  = nz ? pos : last_idx;
    first_n = (nz && !seen) ? pos : first_idx;
    tz_w    = {1'b0, last_n} + 5'd1 - tc_n;
  end

  assign in_ready    = (state == IDLE);
  assign stats_valid = (state == EMIT);
  assign coef_valid  = (state == EMIT) && (scan[ptr] != '0);
  assign coef_level  = coef_valid ? scan[ptr] : '0;
  assign coef_run    = coef_valid ? run[ptr] : 4'd0;
  assign coef_last   = coef_valid && (ptr == first_idx);
  assign beat_take   = coef_valid && coef_ready;
  assign state_dbg   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = COUNT;
      COUNT: if (pos == 4'd15) state_nxt = EMIT;
      EMIT:  if ((tc == 5'd0) || (beat_take && coef_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        scan[i] <= '0;
        run[i]  <= '0;
      end
      pos           <= '0;
      ptr           <= '0;
      zcnt          <= '0;
      last_idx      <= '0;
      first_idx     <= '0;
      tc            <= '0;
      t1            <= '0;
      seen          <= 1'b0;
      total_coeff   <= '0;
      trailing_ones <= '0;
      total_zeros   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) scan[i] <= quantized[ZIGZAG[i]];
            pos           <= '0;
            ptr           <= '0;
            zcnt          <= '0;
            last_idx      <= '0;
            first_idx     <= '0;
            tc            <= '0;
            t1            <= '0;
            seen          <= 1'b0;
            total_coeff   <= '0;
            trailing_ones <= '0;
            total_zeros   <= '0;
          end
        end
        COUNT: begin
          if (nz) run[pos] <= zcnt;
          tc        <= tc_n;
          t1        <= t1_n;
          zcnt      <= zc_n;
          last_idx  <= last_n;
          first_idx <= first_n;
          seen      <= seen | nz;
          pos       <= pos + 4'd1;
          if (pos == 4'd15) begin
            total_coeff   <= tc_n;
            trailing_ones <= t1_n;
            total_zeros   <= (tc_n == 5'd0) ? 4'd0 : tz_w[3:0];
            ptr           <= last_n;
          end
        end
        EMIT: begin
          // Zero positions are skipped one per cycle; the last beat leaves ptr alone.
          if ((scan[ptr] == '0) || (beat_take && !coef_last)) ptr <= ptr - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
